// File: rtl/tx_data_buffer.sv
// 64-byte show-ahead transmit buffer between the bus-side slave and usb_tx.
// Head byte is presented combinationally; occupancy, full, empty and overflow are derived from registered state.
module tx_data_buffer (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       store_tx_data,
    input  logic [7:0] tx_data,
    input  logic       get_tx_packet_data,
    input  logic       clear,
    output logic [7:0] tx_packet_data,
    output logic [6:0] buffer_occupancy,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int unsigned Depth = 64;
    localparam logic [6:0]  OccMax = 7'(Depth);

    logic [7:0] mem_q [Depth];
    logic [5:0] wptr_q, wptr_d;
    logic [5:0] rptr_q, rptr_d;
    logic [6:0] occ_q, occ_d;
    logic       ovf_q, ovf_d;

    logic       full_w;
    logic       empty_w;
    logic       do_read;
    logic       do_write;

    assign full_w  = (occ_q == OccMax);
    assign empty_w = (occ_q == 7'd0);

    // A read frees the head slot at the same edge, so a write is still accepted when full.
    assign do_read  = get_tx_packet_data & ~empty_w;
    assign do_write = store_tx_data & (~full_w | do_read);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        ovf_d  = ovf_q;

        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
            occ_d  = '0;
            ovf_d  = 1'b0;
        end else begin
            if (do_write) begin
                wptr_d = wptr_q + 6'd1;
            end
            if (do_read) begin
                rptr_d = rptr_q + 6'd1;
            end
            unique case ({do_write, do_read})
                2'b10:   occ_d = occ_q + 7'd1;
                2'b01:   occ_d = occ_q - 7'd1;
                default: occ_d = occ_q;
            endcase
            if (store_tx_data && !do_write) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage is deliberately unreset; validity comes only from the pointers and counter.
    always_ff @(posedge clk) begin
        if (do_write && !clear) begin
            mem_q[wptr_q] <= tx_data;
        end
    end

    assign tx_packet_data   = empty_w ? 8'h00 : mem_q[rptr_q];
    assign buffer_occupancy = occ_q;
    assign full             = full_w;
    assign empty            = empty_w;
    assign overflow         = ovf_q;

endmodule

// File: tb/tb_tx_data_buffer.sv
// Self-checking bench for tx_data_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tx_data_buffer;

    logic       clk;
    logic       n_rst;
    logic       store_tx_data;
    logic [7:0] tx_data;
    logic       get_tx_packet_data;
    logic       clear;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       full;
    logic       empty;
    logic       overflow;

    int checks;
    int errors;

    logic [7:0] model_q[$];
    bit         model_ovf;

    tx_data_buffer dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .store_tx_data      (store_tx_data),
        .tx_data            (tx_data),
        .get_tx_packet_data (get_tx_packet_data),
        .clear              (clear),
        .tx_packet_data     (tx_packet_data),
        .buffer_occupancy   (buffer_occupancy),
        .full               (full),
        .empty              (empty),
        .overflow           (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: a FIFO of bytes plus a sticky overflow bit.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else if (clear) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            bit rd;
            bit wr;
            rd = get_tx_packet_data && (model_q.size() > 0);
            wr = store_tx_data && ((model_q.size() < 64) || rd);
            if (store_tx_data && !wr) model_ovf = 1'b1;
            if (rd) void'(model_q.pop_front());
            if (wr) model_q.push_back(tx_data);
        end
    end

    always @(negedge clk) begin
        if (n_rst) begin
            int n;
            n = model_q.size();
            chk("occupancy", int'(buffer_occupancy), n);
            chk("full", int'(full), int'(n == 64));
            chk("empty", int'(empty), int'(n == 0));
            chk("overflow", int'(overflow), int'(model_ovf));
            chk("head", int'(tx_packet_data), (n == 0) ? 0 : int'(model_q[0]));
        end
    end

    // Apply inputs across exactly one rising edge; returns 2 time units after that edge.
    task automatic drive(input bit st, input logic [7:0] d, input bit gt, input bit cl);
        store_tx_data      = st;
        tx_data            = d;
        get_tx_packet_data = gt;
        clear              = cl;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_occ"}, int'(buffer_occupancy), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_data"}, int'(tx_packet_data), 0);
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        n_rst              = 1'b0;
        store_tx_data      = 1'b0;
        tx_data            = 8'h00;
        get_tx_packet_data = 1'b0;
        clear              = 1'b0;

        #3;
        chk_reset_vals("reset");
        #9 n_rst = 1'b1;
        @(posedge clk);
        #2;

        // Two writes, then drain.
        drive(1'b1, 8'hF0, 1'b0, 1'b0);
        drive(1'b1, 8'h0F, 1'b0, 1'b0);
        chk("two_occ", int'(buffer_occupancy), 2);
        chk("two_head", int'(tx_packet_data), 'hF0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("get1_head", int'(tx_packet_data), 'h0F);
        chk("get1_occ", int'(buffer_occupancy), 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("get2_head", int'(tx_packet_data), 0);
        chk("get2_empty", int'(empty), 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("get_empty_occ", int'(buffer_occupancy), 0);
        chk("get_empty_ovf", int'(overflow), 0);

        // Fill to 64, overflow, drain in order.
        for (int i = 0; i < 64; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_full", int'(full), 1);
        chk("fill_occ", int'(buffer_occupancy), 64);
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_occ", int'(buffer_occupancy), 64);
        chk("ovf_head", int'(tx_packet_data), 0);
        for (int i = 0; i < 64; i++) begin
            chk("drain_data", int'(tx_packet_data), i);
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_empty", int'(empty), 1);
        chk("ovf_sticky", int'(overflow), 1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clear_ovf", int'(overflow), 0);

        // Pointer wrap.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 40; i++) drive(1'b1, 8'(100 + 40 * r + i), 1'b0, 1'b0);
            for (int i = 0; i < 40; i++) begin
                chk("wrap_data", int'(tx_packet_data), 100 + 40 * r + i);
                drive(1'b0, 8'h00, 1'b1, 1'b0);
            end
        end
        chk("wrap_occ", int'(buffer_occupancy), 0);
        chk("wrap_ovf", int'(overflow), 0);

        // Simultaneous read and write at 0, 5 and 64.
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        chk("rw0_occ", int'(buffer_occupancy), 1);
        chk("rw0_head", int'(tx_packet_data), 'h55);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(i + 1), 1'b0, 1'b0);
        drive(1'b1, 8'hC5, 1'b1, 1'b0);
        chk("rw5_occ", int'(buffer_occupancy), 5);
        chk("rw5_head", int'(tx_packet_data), 1);
        for (int i = 0; i < 59; i++) drive(1'b1, 8'(i + 8'h20), 1'b0, 1'b0);
        chk("rw64_pre_full", int'(full), 1);
        drive(1'b1, 8'hE4, 1'b1, 1'b0);
        chk("rw64_occ", int'(buffer_occupancy), 64);
        chk("rw64_ovf", int'(overflow), 0);
        chk("rw64_head", int'(tx_packet_data), 2);
        for (int i = 0; i < 64; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rw_drained", int'(empty), 1);

        // Clear beats simultaneous read and write.
        for (int i = 0; i < 10; i++) drive(1'b1, 8'(i + 8'h40), 1'b0, 1'b0);
        drive(1'b1, 8'h77, 1'b1, 1'b1);
        chk("clr_occ", int'(buffer_occupancy), 0);
        chk("clr_empty", int'(empty), 1);
        chk("clr_ovf", int'(overflow), 0);
        drive(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("clr_newhead", int'(tx_packet_data), 'h3C);
        drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Randomized traffic; write-heavy and read-heavy phases alternate to reach both bounds.
        for (int n = 0; n < 3000; n++) begin
            int wp;
            int rp;
            wp = ((n / 300) % 2 == 0) ? 80 : 30;
            rp = ((n / 300) % 2 == 0) ? 30 : 80;
            drive(1'($urandom_range(0, 99) < wp), 8'($urandom), 1'($urandom_range(0, 99) < rp),
                  1'($urandom_range(0, 399) == 0));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset between edges at occupancy 7.
        for (int i = 0; i < 7; i++) drive(1'b1, 8'(i + 8'h60), 1'b0, 1'b0);
        chk("pre_rst_occ", int'(buffer_occupancy), 7);
        #1 n_rst = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        store_tx_data      = 1'b1;
        get_tx_packet_data = 1'b1;
        tx_data            = 8'hEE;
        @(posedge clk);
        #2;
        chk_reset_vals("rst_held");
        n_rst = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk_reset_vals("post_rst_get");
        drive(1'b1, 8'h9A, 1'b0, 1'b0);
        chk("post_rst_head", int'(tx_packet_data), 'h9A);
        chk("post_rst_occ", int'(buffer_occupancy), 1);
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_data_buffer.md
TX_DATA_BUFFER -- requirements
Module: tx_data_buffer

Interface
REQ-001 SHALL have no parameters; depth is fixed at 64 bytes.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 store_tx_data  input  1  write strobe from the bus-side slave; one byte per cycle high.
REQ-005 tx_data  input  8  byte written when store_tx_data is high.
REQ-006 get_tx_packet_data  input  1  read strobe from usb_tx; one byte consumed per cycle high.
REQ-007 clear  input  1  synchronous flush of all buffered data.
REQ-008 tx_packet_data  output  8  byte at the head of the buffer (show-ahead).
REQ-009 buffer_occupancy  output  7  bytes held, 0..64; drives usb_tx tx_packet_size.
REQ-010 full  output  1  high when buffer_occupancy == 64.
REQ-011 empty  output  1  high when buffer_occupancy == 0.
REQ-012 overflow  output  1  sticky flag: a write was attempted while full.

Function
REQ-013 Storage: 64 x 8 register array; 6-bit write pointer and 6-bit read pointer; both wrap 63 -> 0.
REQ-014 Occupancy: 7-bit counter, registered, never exceeds 64 and never goes below 0.
REQ-015 Write: store_tx_data high and not full -> tx_data stored at write pointer, write pointer +1, occupancy +1, all at the same edge.
REQ-016 Write when full and no read in the same cycle -> byte dropped, pointers and occupancy unchanged, overflow set at that edge.
REQ-017 Read: get_tx_packet_data high and not empty -> read pointer +1, occupancy -1 at that edge.
REQ-018 Read when empty -> ignored; no pointer or occupancy change, no error flag.
REQ-019 tx_packet_data is combinational from the array at the read pointer; valid in the same cycle get_tx_packet_data is asserted (zero-latency show-ahead).
REQ-020 tx_packet_data = 8'h00 whenever empty is high.
REQ-021 Simultaneous read and write, occupancy 1..63 -> both performed, occupancy unchanged.
REQ-022 Simultaneous read and write when full -> both performed, no overflow, occupancy stays 64.
REQ-023 Simultaneous read and write when empty -> write performed, read ignored, occupancy becomes 1.
REQ-024 A byte written at edge N is visible on tx_packet_data from edge N onward if it is the new head (write-to-read latency: 1 cycle).
REQ-025 clear has priority over read and write: at the edge, both pointers -> 0, occupancy -> 0, overflow -> 0; a write or read in the same cycle is discarded.
REQ-026 full, empty and overflow are registered or decoded from registered state only; no combinational path from strobes to these outputs.
REQ-027 Array contents are not reset and not cleared; only pointers and counter define validity.

Reset
REQ-028 On n_rst low, asynchronously: pointers 0, occupancy 0, overflow 0; hence empty 1, full 0, tx_packet_data 8'h00.
REQ-029 Reset asserted mid-transfer discards all buffered bytes; after release the first write becomes the new head.
REQ-030 With n_rst low, all strobes are ignored.

Verification
REQ-031 Reset, then write 8'hF0, 8'h0F -> occupancy 2, tx_packet_data F0; pulse get -> 0F, occupancy 1; pulse get -> 00, empty 1.
REQ-032 Write 64 bytes 0..63 -> full 1, occupancy 64; write 8'hAA -> overflow 1, data dropped; read 64 -> bytes 0..63 in order, empty 1.
REQ-033 Pointer wrap: write 40, read 40, write 40, read 40 -> data in order, occupancy ends 0, no overflow.
REQ-034 Simultaneous read and write at occupancy 0, 5 and 64 -> occupancy 1, 5 and 64; overflow stays 0; order preserved.
REQ-035 Fill to 10, assert clear together with store_tx_data and get -> occupancy 0, empty 1, overflow 0; next write becomes head.
REQ-036 Assert n_rst low between clock edges at occupancy 7 -> outputs reach reset values before the next edge; get on empty afterwards -> no change.
